stitch_video_out: RTL and testbench

STITCH_VIDEO_OUT -- requirements
Module: stitch_video_out

---
 rtl/video_out_pkg.sv | 49 ++++
 rtl/video_timing_cnt.sv | 59 +++++
 rtl/stitch_video_out.sv | 143 ++++++++++++++
 tb/tb_stitch_video_out.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_out_pkg.sv
// Shared video output definitions: 1080p60 timing defaults, raster totals,
// output FSM states and the 8-bar test pattern colour table.
package video_out_pkg;

  localparam int unsigned DEF_H_DISP     = 1920;
  localparam int unsigned DEF_H_FP       = 88;
  localparam int unsigned DEF_H_SYNC     = 44;
  localparam int unsigned DEF_H_BP       = 148;
  localparam int unsigned DEF_V_DISP     = 1080;
  localparam int unsigned DEF_V_FP       = 4;
  localparam int unsigned DEF_V_SYNC     = 5;
  localparam int unsigned DEF_V_BP       = 36;
  localparam int unsigned DEF_DATA_WIDTH = 24;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned UF_W           = 16;

  // Raster total for one axis: sync + back porch + active + front porch.
  function automatic int unsigned raster_total(input int unsigned sync_w, input int unsigned bp,
                                               input int unsigned disp, input int unsigned fp);
    return sync_w + bp + disp + fp;
  endfunction

  localparam int unsigned DEF_H_TOTAL = raster_total(DEF_H_SYNC, DEF_H_BP, DEF_H_DISP, DEF_H_FP);
  localparam int unsigned DEF_V_TOTAL = raster_total(DEF_V_SYNC, DEF_V_BP, DEF_V_DISP, DEF_V_FP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Colour bars left to right, 24-bit RGB.
  function automatic logic [23:0] tpg_colour(input logic [2:0] idx);
    logic [23:0] rgb;
    rgb = 24'h000000;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counters with sync and data-enable decode.
module video_timing_cnt
  import video_out_pkg::*;
#(
  parameter int unsigned H_DISP = DEF_H_DISP,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_DISP = DEF_V_DISP,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] h_cnt,
  output logic             hsync_c,
  output logic             vsync_c,
  output logic             de_c,
  output logic             frame_end_c
);
  localparam int unsigned H_TOTAL = raster_total(H_SYNC, H_BP, H_DISP, H_FP);
  localparam int unsigned V_TOTAL = raster_total(V_SYNC, V_BP, V_DISP, V_FP);
  localparam int unsigned H_ACT0  = H_SYNC + H_BP;
  localparam int unsigned H_ACT1  = H_ACT0 + H_DISP;
  localparam int unsigned V_ACT0  = V_SYNC + V_BP;
  localparam int unsigned V_ACT1  = V_ACT0 + V_DISP;

  logic [CNT_W-1:0] v_cnt;
  logic             h_last_c;
  logic             v_last_c;

  assign h_last_c    = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last_c    = (v_cnt == CNT_W'(V_TOTAL - 1));
  assign frame_end_c = h_last_c & v_last_c;

  // Counters sit at the raster origin whenever the output is stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign hsync_c = (h_cnt < CNT_W'(H_SYNC));
  assign vsync_c = (v_cnt < CNT_W'(V_SYNC));
  assign de_c    = (h_cnt >= CNT_W'(H_ACT0)) && (h_cnt < CNT_W'(H_ACT1)) &&
                   (v_cnt >= CNT_W'(V_ACT0)) && (v_cnt < CNT_W'(V_ACT1));

endmodule

// File: rtl/stitch_video_out.sv
// Video output stage: raster timing, pixel FIFO pacing, underflow accounting.
// Optional 8-bar colour test pattern is compiled in with STITCH_VIDEO_TPG_EN.
module stitch_video_out
  import video_out_pkg::*;
#(
  parameter int unsigned H_DISP     = DEF_H_DISP,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_DISP     = DEF_V_DISP,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  video_clk,
  input  logic                  rst_n,
  input  logic                  out_en,
  input  logic                  tpg_en,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  frame_start,
  output logic                  video_vsync,
  output logic                  video_hsync,
  output logic                  video_de,
  output logic [DATA_WIDTH-1:0] video_data,
  output logic [UF_W-1:0]       underflow_cnt
);
  state_e           state_q, state_d;
  logic             frame_start_d;
  logic             running_c;
  logic             frame_end_c;
  logic             hsync_i, vsync_i, de_i;
  logic             underflow_c;
  logic             rd_q;
  logic             tpg_active;
  logic [CNT_W-1:0] h_cnt;

  assign running_c = (state_q != ST_IDLE);

  video_timing_cnt #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (video_clk),
    .rst_n      (rst_n),
    .en         (running_c),
    .h_cnt      (h_cnt),
    .hsync_c    (hsync_i),
    .vsync_c    (vsync_i),
    .de_c       (de_i),
    .frame_end_c(frame_end_c)
  );

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A stop request while already on the last pixel goes straight to IDLE.
  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (out_en) begin
          state_d       = ST_RUN;
          frame_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!out_en)          state_d = frame_end_c ? ST_IDLE : ST_DRAIN;
        else if (frame_end_c) frame_start_d = 1'b1;
      end
      ST_DRAIN: begin
        if (out_en) begin
          state_d       = ST_RUN;
          frame_start_d = frame_end_c;
        end else if (frame_end_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_rd_en  = running_c & de_i & ~fifo_empty & ~tpg_active;
  assign underflow_c = running_c & de_i & fifo_empty & ~tpg_active;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start   <= 1'b0;
      video_vsync   <= 1'b0;
      video_hsync   <= 1'b0;
      video_de      <= 1'b0;
      rd_q          <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      frame_start <= frame_start_d;
      video_vsync <= running_c & vsync_i;
      video_hsync <= running_c & hsync_i;
      video_de    <= running_c & de_i;
      rd_q        <= fifo_rd_en;
      if (underflow_c && (underflow_cnt != {UF_W{1'b1}}))
        underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

`ifdef STITCH_VIDEO_TPG_EN
  localparam int unsigned H_ACT0 = H_SYNC + H_BP;

  logic [CNT_W-1:0]      act_x;
  logic [2:0]            bar_idx;
  logic                  tpg_q;
  logic [DATA_WIDTH-1:0] tpg_data_q;

  assign act_x   = h_cnt - CNT_W'(H_ACT0);
  assign bar_idx = 3'((32'(act_x) * 32'd8) / 32'(H_DISP));

  // Pattern select is latched per frame so a mid-frame toggle cannot tear the image.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      tpg_active <= 1'b0;
      tpg_q      <= 1'b0;
      tpg_data_q <= '0;
    end else begin
      if (frame_start_d) tpg_active <= tpg_en;
      tpg_q      <= running_c & de_i & tpg_active;
      tpg_data_q <= DATA_WIDTH'(tpg_colour(bar_idx));
    end
  end

  assign video_data = rd_q ? fifo_rd_data : (tpg_q ? tpg_data_q : '0);
`else
  logic unused_tpg;

  assign tpg_active = 1'b0;
  assign unused_tpg = ^{tpg_en, h_cnt};
  assign video_data = rd_q ? fifo_rd_data : '0;
`endif

endmodule

// File: tb/tb_stitch_video_out.sv
// Directed bench for stitch_video_out on a 14x7 raster plus a wide raster for
// underflow saturation; the pattern scenario is built with STITCH_VIDEO_TPG_EN.
module tb_stitch_video_out;
  localparam int H_TOT      = 14;
  localparam int V_TOT      = 7;
  localparam int FRAME      = 98;
  localparam int FIRST_DE   = 33;
  localparam int SAT_CYCLES = 71890;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_en = 1'b0;
  logic        tpg_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [23:0] fifo_rd_data = 24'd0;
  logic [23:0] fifo_next = 24'd1;
  logic [23:0] exp_pix = 24'd1;

  logic        fifo_rd_en, frame_start, video_vsync, video_hsync, video_de;
  logic [23:0] video_data;
  logic [15:0] underflow_cnt;

  logic        sat_out_en = 1'b0;
  logic        sat_fifo_rd_en;
  logic [15:0] sat_underflow_cnt;
  logic        sat_unused_fs, sat_unused_vs, sat_unused_hs, sat_unused_de;
  logic [23:0] sat_unused_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stitch_video_out #(
    .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .DATA_WIDTH(24)
  ) dut (
    .video_clk(clk), .rst_n(rst_n), .out_en(out_en), .tpg_en(tpg_en),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .frame_start(frame_start), .video_vsync(video_vsync), .video_hsync(video_hsync),
    .video_de(video_de), .video_data(video_data), .underflow_cnt(underflow_cnt)
  );

  stitch_video_out #(
    .H_DISP(1024), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_DISP(64), .V_FP(1), .V_SYNC(1), .V_BP(1), .DATA_WIDTH(24)
  ) u_sat (
    .video_clk(clk), .rst_n(rst_n), .out_en(sat_out_en), .tpg_en(1'b0),
    .fifo_rd_en(sat_fifo_rd_en), .fifo_rd_data(24'd0), .fifo_empty(1'b1),
    .frame_start(sat_unused_fs), .video_vsync(sat_unused_vs), .video_hsync(sat_unused_hs),
    .video_de(sat_unused_de), .video_data(sat_unused_data), .underflow_cnt(sat_underflow_cnt)
  );

  // Pixel FIFO model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifo_next;
      fifo_next    <= fifo_next + 24'd1;
    end
  end

  // Active region of the 14x7 raster: h 4..11, v 2..5.
  function automatic bit de_at(input int k);
    int h, v;
    if (k < 0) return 1'b0;
    h = k % H_TOT;
    v = (k / H_TOT) % V_TOT;
    return (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
  endfunction

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL frame_start_wait: actual=timeout required=pulse");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; out_en = 1'b0; tpg_en = 1'b0; fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({frame_start, video_vsync, video_hsync, video_de, fifo_rd_en} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: actual=%b required=00000",
               {frame_start, video_vsync, video_hsync, video_de, fifo_rd_en});
    end
    n_cmp++;
    if (video_data !== 24'd0) begin
      n_bad++; $display("FAIL reset_data: actual=%h required=000000", video_data);
    end
    n_cmp++;
    if (underflow_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_uf: actual=%0d required=0", underflow_cnt);
    end
    rst_n = 1'b1; fifo_empty = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({frame_start, video_vsync, video_hsync, video_de, fifo_rd_en} !== 5'b0) begin
      n_bad++;
      $display("FAIL idle_ctrl: actual=%b required=00000",
               {frame_start, video_vsync, video_hsync, video_de, fifo_rd_en});
    end
  endtask

  task automatic test_frame;
    bit ok;
    int first_de = -1, de_cnt = 0, bad_pix = 0, fs_cnt = 0, bad_fs = 0, bad_rd = 0;
    int bad_de = 0, hs_bad = 0, hs_rises = 0, last_rise = -1, vs_cnt = 0;
    logic hs_prev = 1'b0;
    logic [23:0] first_data = 24'd0;
    fifo_empty = 1'b0; out_en = 1'b1;
    wait_frame_start(ok);
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (frame_start) begin
        fs_cnt++;
        if (c != 0 && c != FRAME) bad_fs++;
      end
      if (fifo_rd_en !== de_at(c)) bad_rd++;
      if (video_de !== de_at(c - 1)) bad_de++;
      if (video_de) begin
        if (first_de < 0) begin first_de = c; first_data = video_data; end
        if (c < FRAME) de_cnt++;
        if (video_data !== exp_pix) bad_pix++;
        exp_pix++;
      end else if (video_data !== 24'd0) begin
        bad_pix++;
      end
      if (video_hsync && !hs_prev) begin
        if (last_rise >= 0 && c - last_rise != H_TOT) hs_bad++;
        last_rise = c; hs_rises++;
      end
      hs_prev = video_hsync;
      if (c < FRAME && video_vsync) vs_cnt++;
    end
    n_cmp++;
    if (first_de != FIRST_DE) begin
      n_bad++; $display("FAIL first_de_cycle: actual=%0d required=%0d", first_de, FIRST_DE);
    end
    n_cmp++;
    if (first_data !== 24'd1) begin
      n_bad++; $display("FAIL first_pixel: actual=%h required=000001", first_data);
    end
    n_cmp++;
    if (de_cnt != 32) begin n_bad++; $display("FAIL de_per_frame: actual=%0d required=32", de_cnt); end
    n_cmp++;
    if (fs_cnt != 2 || bad_fs != 0) begin
      n_bad++; $display("FAIL frame_start_period: actual=%0d/%0d required=2/0", fs_cnt, bad_fs);
    end
    n_cmp++;
    if (bad_rd != 0) begin n_bad++; $display("FAIL rd_en_timing: actual=%0d required=0", bad_rd); end
    n_cmp++;
    if (bad_de != 0) begin n_bad++; $display("FAIL de_timing: actual=%0d required=0", bad_de); end
    n_cmp++;
    if (bad_pix != 0) begin n_bad++; $display("FAIL pixel_stream: actual=%0d required=0", bad_pix); end
    n_cmp++;
    if (hs_bad != 0 || hs_rises != 14) begin
      n_bad++; $display("FAIL hsync_period: actual=%0d/%0d required=0/14", hs_bad, hs_rises);
    end
    n_cmp++;
    if (vs_cnt != H_TOT) begin n_bad++; $display("FAIL vsync_width: actual=%0d required=14", vs_cnt); end
  endtask

  task automatic test_underflow;
    bit ok, gap;
    int bad_rd = 0, bad_pix = 0, zero_pix = 0, de_cnt = 0, hs_bad = 0, last_rise = -1;
    logic hs_prev = 1'b0;
    wait_frame_start(ok);
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      fifo_empty = (c >= 34 && c <= 36);
      #1;
      if (fifo_rd_en !== (de_at(c) && !fifo_empty)) bad_rd++;
      gap = (c >= 35 && c <= 37);
      if (video_de) begin
        de_cnt++;
        if (gap) begin
          if (video_data === 24'd0) zero_pix++;
        end else begin
          if (video_data !== exp_pix) bad_pix++;
          exp_pix++;
        end
      end
      if (video_hsync && !hs_prev) begin
        if (last_rise >= 0 && c - last_rise != H_TOT) hs_bad++;
        last_rise = c;
      end
      hs_prev = video_hsync;
    end
    fifo_empty = 1'b0;
    n_cmp++;
    if (underflow_cnt !== 16'd3) begin
      n_bad++; $display("FAIL underflow_count: actual=%0d required=3", underflow_cnt);
    end
    n_cmp++;
    if (zero_pix != 3) begin n_bad++; $display("FAIL underflow_zero_px: actual=%0d required=3", zero_pix); end
    n_cmp++;
    if (bad_rd != 0) begin n_bad++; $display("FAIL underflow_rd_en: actual=%0d required=0", bad_rd); end
    n_cmp++;
    if (bad_pix != 0 || de_cnt != 32) begin
      n_bad++; $display("FAIL underflow_stream: actual=%0d/%0d required=0/32", bad_pix, de_cnt);
    end
    n_cmp++;
    if (hs_bad != 0) begin n_bad++; $display("FAIL underflow_hsync: actual=%0d required=0", hs_bad); end
  endtask

  task automatic test_drain;
    bit ok;
    int de_cnt = 0, fs_cnt = 0, bad_idle = 0, bad_pix = 0;
    wait_frame_start(ok);
    for (int c = 0; c <= FRAME + 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c > 0 && frame_start) fs_cnt++;
      if (video_de) begin
        de_cnt++;
        if (video_data !== exp_pix) bad_pix++;
        exp_pix++;
      end
      if (c > FRAME && ({frame_start, video_vsync, video_hsync, video_de, fifo_rd_en} !== 5'b0
                        || video_data !== 24'd0)) bad_idle++;
      if (c == 40) out_en = 1'b0;
    end
    n_cmp++;
    if (de_cnt != 32) begin n_bad++; $display("FAIL drain_de_count: actual=%0d required=32", de_cnt); end
    n_cmp++;
    if (bad_pix != 0) begin n_bad++; $display("FAIL drain_pixels: actual=%0d required=0", bad_pix); end
    n_cmp++;
    if (fs_cnt != 0) begin n_bad++; $display("FAIL drain_frame_start: actual=%0d required=0", fs_cnt); end
    n_cmp++;
    if (bad_idle != 0) begin n_bad++; $display("FAIL drain_idle_out: actual=%0d required=0", bad_idle); end
  endtask

`ifdef STITCH_VIDEO_TPG_EN
  task automatic test_tpg;
    bit ok;
    int bad_rd = 0, bad_pix = 0, de_cnt = 0, x;
    logic [23:0] bars [8];
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    tpg_en = 1'b1; fifo_empty = 1'b1; out_en = 1'b1;
    wait_frame_start(ok);
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (fifo_rd_en !== 1'b0) bad_rd++;
      if (video_de !== de_at(c - 1)) bad_pix++;
      if (video_de) begin
        de_cnt++;
        x = ((c - 1) % H_TOT) - 4;
        if (video_data !== bars[x]) bad_pix++;
      end
      if (c == FRAME - 1) out_en = 1'b0;
    end
    repeat (3) @(negedge clk);
    tpg_en = 1'b0; fifo_empty = 1'b0;
    n_cmp++;
    if (bad_rd != 0) begin n_bad++; $display("FAIL tpg_rd_en: actual=%0d required=0", bad_rd); end
    n_cmp++;
    if (bad_pix != 0 || de_cnt != 32) begin
      n_bad++; $display("FAIL tpg_bars: actual=%0d/%0d required=0/32", bad_pix, de_cnt);
    end
    n_cmp++;
    if (underflow_cnt !== 16'd3) begin
      n_bad++; $display("FAIL tpg_underflow: actual=%0d required=3", underflow_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid;
    bit ok;
    out_en = 1'b1; fifo_empty = 1'b0;
    wait_frame_start(ok);
    repeat (36) @(negedge clk);
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin
      n_bad++; $display("FAIL midline_rd_en: actual=%b required=1", fifo_rd_en);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({frame_start, video_vsync, video_hsync, video_de, fifo_rd_en} !== 5'b0 || video_data !== 24'd0) begin
      n_bad++;
      $display("FAIL async_reset_out: actual=%b/%h required=00000/000000",
               {frame_start, video_vsync, video_hsync, video_de, fifo_rd_en}, video_data);
    end
    n_cmp++;
    if (underflow_cnt !== 16'd0) begin
      n_bad++; $display("FAIL async_reset_uf: actual=%0d required=0", underflow_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (frame_start !== 1'b1) begin
      n_bad++; $display("FAIL restart_frame_start: actual=%b required=1", frame_start);
    end
    @(negedge clk);
    n_cmp++;
    if ({frame_start, video_vsync, video_hsync} !== 3'b011) begin
      n_bad++; $display("FAIL restart_sync: actual=%b required=011", {frame_start, video_vsync, video_hsync});
    end
    rst_n = 1'b0; out_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturate;
    int bad_rd = 0;
    sat_out_en = 1'b1;
    for (int i = 0; i < SAT_CYCLES; i++) begin
      @(negedge clk);
      if (sat_fifo_rd_en !== 1'b0) bad_rd++;
      if (i == 3081) begin
        n_cmp++;
        if (sat_underflow_cnt !== 16'd1024) begin
          n_bad++; $display("FAIL sat_first_line: actual=%0d required=1024", sat_underflow_cnt);
        end
      end
    end
    sat_out_en = 1'b0;
    n_cmp++;
    if (sat_underflow_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_hold: actual=%h required=ffff", sat_underflow_cnt);
    end
    n_cmp++;
    if (bad_rd != 0) begin n_bad++; $display("FAIL sat_rd_en: actual=%0d required=0", bad_rd); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_frame();
    test_underflow();
    test_drain();
`ifdef STITCH_VIDEO_TPG_EN
    test_tpg();
`endif
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
